// File: rtl/sym_src.sv
// sym_src: BPSK symbol source and rate-strobe generator.
// Produces the sample strobe cke (every clk_div clks), the symbol strobe den
// (every ovs-th cke) and a framed symbol stream: alternating preamble, PRBS
// payload, zero gap. dout is prefetched one symbol ahead of den.
// Build option: define SYM_SRC_PRBS15_EN to switch the payload from PRBS9
// (x^9+x^5+1) to PRBS15 (x^15+x^14+1).
module sym_src #(
  parameter int                      width     = 16,
  parameter int                      clk_div   = 4,
  parameter int                      ovs       = 10,
  parameter logic signed [width-1:0] amp       = 16'sh4000,
  parameter int                      pre_len   = 32,
  parameter int                      frame_len = 256,
  parameter int                      gap_len   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic                    cke,
  output logic                    den,
  output logic signed [width-1:0] dout,
  output logic                    sof,
  output logic                    busy
);

`ifdef SYM_SRC_PRBS15_EN
  localparam int prbs_w   = 15;
  localparam int prbs_tap = 13;
`else
  localparam int prbs_w   = 9;
  localparam int prbs_tap = 4;
`endif

  localparam int div_w   = $clog2(clk_div);
  localparam int ph_w    = $clog2(ovs);
  localparam int cnt_max = (pre_len > frame_len) ?
                           ((pre_len > gap_len) ? pre_len : gap_len) :
                           ((frame_len > gap_len) ? frame_len : gap_len);
  localparam int cnt_w   = $clog2(cnt_max + 1);

  localparam logic [div_w-1:0]        div_last = div_w'(clk_div - 1);
  localparam logic [ph_w-1:0]         ph_last  = ph_w'(ovs - 1);
  localparam logic [cnt_w-1:0]        pre_last = cnt_w'(pre_len - 1);
  localparam logic [cnt_w-1:0]        pay_last = cnt_w'(frame_len - 1);
  localparam logic [cnt_w-1:0]        gap_last = cnt_w'(gap_len - 1);
  localparam logic [prbs_w-1:0]       seed     = '1;
  localparam logic signed [width-1:0] neg_amp  = -amp;

  // The state names which kind of symbol is currently held (prefetched) in dout.
  typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;

  logic [div_w-1:0]        div_q, div_d;
  logic [ph_w-1:0]         ph_q, ph_d;
  state_t                  state_q, state_d;
  logic [cnt_w-1:0]        cnt_q, cnt_d;
  logic [prbs_w-1:0]       prbs_q, prbs_d;
  logic signed [width-1:0] dout_q, dout_d;
  logic                    sof_pend_q, sof_pend_d;
  logic                    fb;

  assign cke  = (div_q == div_last);
  assign den  = cke && (ph_q == ph_last);
  assign dout = dout_q;
  assign sof  = den && sof_pend_q;
  assign busy = (state_q != IDLE);
  assign fb   = prbs_q[prbs_w-1] ^ prbs_q[prbs_tap];

  // Free-running sample divider and symbol phase counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    div_d = div_q + 1'b1;
    ph_d  = ph_q;
    if (cke) begin
      div_d = '0;
      ph_d  = (ph_q == ph_last) ? '0 : ph_q + 1'b1;
    end
  end

  // Framing FSM: at each den edge, load the symbol for the next den and advance.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prbs_d     = prbs_q;
    dout_d     = dout_q;
    sof_pend_d = sof_pend_q;
    if (den) begin
      sof_pend_d = 1'b0;
      cnt_d      = cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          cnt_d  = '0;
          dout_d = '0;
          if (en) begin
            state_d    = PRE;
            prbs_d     = seed;
            dout_d     = amp;
            sof_pend_d = 1'b1;
          end
        end
        PRE: begin
          if (cnt_q == pre_last) begin
            state_d = PAY;
            cnt_d   = '0;
            prbs_d  = {prbs_q[prbs_w-2:0], fb};
            dout_d  = fb ? neg_amp : amp;
          end else begin
            // Next index is odd when the current one is even.
            dout_d = cnt_q[0] ? amp : neg_amp;
          end
        end
        PAY: begin
          if (cnt_q == pay_last) begin
            state_d = GAP;
            cnt_d   = '0;
            dout_d  = '0;
          end else begin
            prbs_d = {prbs_q[prbs_w-2:0], fb};
            dout_d = fb ? neg_amp : amp;
          end
        end
        GAP: begin
          dout_d = '0;
          if (cnt_q == gap_last) begin
            cnt_d = '0;
            if (en) begin
              state_d    = PRE;
              prbs_d     = seed;
              dout_d     = amp;
              sof_pend_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          dout_d  = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      div_q      <= '0;
      ph_q       <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      prbs_q     <= seed;
      dout_q     <= '0;
      sof_pend_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      ph_q       <= ph_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prbs_q     <= prbs_d;
      dout_q     <= dout_d;
      sof_pend_q <= sof_pend_d;
    end
  end

endmodule

// File: tb/tb_sym_src.sv
// tb_sym_src: scoreboard bench for sym_src at default parameters.
// Expected per-den symbols are pushed from an independent frame/PRBS model and
// compared as den pulses arrive. Outputs are sampled on the falling edge.
module tb_sym_src;

`ifdef SYM_SRC_PRBS15_EN
  localparam int pw = 15, ptap = 13, lit_n = 15, lit_pos = 14;
`else
  localparam int pw = 9, ptap = 4, lit_n = 9, lit_pos = 5;
`endif
  localparam logic signed [15:0] A  = 16'sh4000;
  localparam logic signed [15:0] NA = -16'sh4000;

  typedef struct {
    logic signed [15:0] d;
    logic               s;
    logic               b;
    int                 c;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en  = 1'b0;
  logic               cke, den, sof, busy;
  logic signed [15:0] dout;

  int                 n_assert = 0;
  int                 n_fail   = 0;
  int                 cyc      = 0;
  exp_t               exp_q[$];
  logic signed [15:0] obs_q[$];

  sym_src dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .cke (cke),
    .den (den),
    .dout(dout),
    .sof (sof),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle index relative to the last reset edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic do_reset(input logic en_v);
    @(negedge clk);
    rst = 1'b1;
    en  = en_v;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic push(input logic signed [15:0] d, input logic s, input logic b, input int c);
    exp_t e;
    e.d = d; e.s = s; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_pre(input int c0);
    for (int i = 0; i < 32; i++)
      push((i % 2 == 1) ? NA : A, (i == 0), 1'b1, (i == 0) ? c0 : -1);
  endtask

  task automatic push_pay();
    logic [14:0] ms;
    logic        fbm;
    ms = '0;
    for (int i = 0; i < pw; i++) ms[i] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      fbm = ms[pw-1] ^ ms[ptap];
      ms  = {ms[13:0], fbm};
      ms[14] = (pw == 15) ? ms[14] : 1'b0;
      if (pw < 15) for (int k = pw; k < 15; k++) ms[k] = 1'b0;
      push(fbm ? NA : A, 1'b0, 1'b1, -1);
    end
  endtask

  task automatic push_gap();
    for (int i = 0; i < 16; i++) push(16'sd0, 1'b0, 1'b1, -1);
  endtask

  task automatic wait_den(output bit got);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (den === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Pop and compare one expected symbol per den; optionally drop en after index drop_at.
  task automatic run_dens(input int drop_at);
    exp_t e;
    bit   got;
    int   idx = 0;
    while (exp_q.size() > 0) begin
      wait_den(got);
      if (!got) begin
        n_assert++; n_fail++;
        $display("FAIL den_timeout: no den within 100 cycles at index %0d", idx);
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      obs_q.push_back(dout);
      n_assert++;
      if (dout !== e.d) begin
        n_fail++;
        $display("FAIL dout[%0d]: got %0d expected %0d", idx, dout, e.d);
      end
      n_assert++;
      if (sof !== e.s) begin
        n_fail++;
        $display("FAIL sof[%0d]: got %b expected %b", idx, sof, e.s);
      end
      n_assert++;
      if (busy !== e.b) begin
        n_fail++;
        $display("FAIL busy[%0d]: got %b expected %b", idx, busy, e.b);
      end
      if (e.c >= 0) begin
        n_assert++;
        if (cyc != e.c) begin
          n_fail++;
          $display("FAIL den_cycle[%0d]: got %0d expected %0d", idx, cyc, e.c);
        end
      end
      if (idx == drop_at) en = 1'b0;
      idx++;
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_assert++;
    if ({cke, den, sof, busy} !== 4'b0000 || dout !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_state: got cke=%b den=%b sof=%b busy=%b dout=%0d expected all 0",
               cke, den, sof, busy, dout);
    end
  endtask

  // Continues straight from test_reset: we are in cycle 0 with en low.
  task automatic test_strobes();
    for (int c = 0; c < 120; c++) begin
      n_assert++;
      if (cke !== (cyc % 4 == 3)) begin
        n_fail++;
        $display("FAIL cke@%0d: got %b expected %b", cyc, cke, (cyc % 4 == 3));
      end
      n_assert++;
      if (den !== (cyc % 40 == 39)) begin
        n_fail++;
        $display("FAIL den@%0d: got %b expected %b", cyc, den, (cyc % 40 == 39));
      end
      n_assert++;
      if (dout !== 16'sd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_out@%0d: got dout=%0d busy=%b expected 0 0", cyc, dout, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_frame();
    logic signed [15:0] lit;
    do_reset(1'b1);
    push(16'sd0, 1'b0, 1'b0, 39);
    push_pre(79);
    push_pay();
    push_gap();
    push_pre(-1);
    push_pay();
    run_dens(-1);
    // Fixed leading payload pattern; payload starts after 1 idle + 32 preamble dens.
    for (int i = 0; i < lit_n; i++) begin
      lit = (i < lit_pos) ? A : NA;
      n_assert++;
      if (obs_q.size() <= 33 + i || obs_q[33 + i] !== lit) begin
        n_fail++;
        $display("FAIL pay_lit[%0d]: got %0d expected %0d", i,
                 (obs_q.size() > 33 + i) ? obs_q[33 + i] : 16'sd0, lit);
      end
    end
  endtask

  task automatic test_en_drop();
    do_reset(1'b1);
    push(16'sd0, 1'b0, 1'b0, 39);
    push_pre(79);
    push_pay();
    push_gap();
    for (int i = 0; i < 3; i++) push(16'sd0, 1'b0, 1'b0, -1);
    run_dens(33 + 100);
  endtask

  task automatic test_rst_mid();
    bit got;
    do_reset(1'b1);
    for (int i = 0; i < 60; i++) begin
      wait_den(got);
      if (!got) begin
        n_assert++; n_fail++;
        $display("FAIL rst_mid_timeout: no den at %0d", i);
        break;
      end
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({cke, den, sof, busy} !== 4'b0000 || dout !== 16'sd0) begin
      n_fail++;
      $display("FAIL rst_mid_state: got cke=%b den=%b sof=%b busy=%b dout=%0d expected all 0",
               cke, den, sof, busy, dout);
    end
    rst = 1'b0;
    exp_q.delete();
    push(16'sd0, 1'b0, 1'b0, 39);
    push(A, 1'b1, 1'b1, 79);
    run_dens(-1);
  endtask

  initial begin
    test_reset();
    test_strobes();
    test_frame();
    test_en_drop();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sym_src.md
# sym_src

BPSK symbol source and rate-strobe generator for the transmit chain. Generates the sample-rate strobe `cke` and symbol strobe `den` that drive the 10-phase polyphase raised-cosine interpolator directly downstream. Presents one signed symbol per `den` on `dout`. Symbols are produced in a framed sequence of preamble, PRBS payload and zero gap.

## Interface
Parameters:
- `width`, 16 — symbol sample width; matches the interpolator `width`.
- `clk_div`, 4 — clk cycles per output sample (`cke` period); ≥ 2.
- `ovs`, 10 — samples per symbol; must equal the interpolator phase count (10).
- `amp`, 16'sh4000 — symbol magnitude; positive; must not be the most-negative value.
- `pre_len`, 32 — preamble length in symbols; ≥ 1.
- `frame_len`, 256 — payload length in symbols; ≥ 1.
- `gap_len`, 16 — zero-symbol gap after payload; ≥ 1.

Ports:
- `clk`  in  1  — clock.
- `rst`  in  1  — reset, synchronous, active-high.
- `en`  in  1  — run request, level.
- `cke`  out  1  — one-clk pulse every `clk_div` clks.
- `den`  out  1  — one-clk pulse, coincident with every `ovs`-th `cke`.
- `dout`  out  `width` signed — symbol value; valid while `den` = 1.
- `sof`  out  1  — high with `den` carrying the first preamble symbol.
- `busy`  out  1  — high when state ≠ IDLE.

## Operation
- Divider `div` counts 0..`clk_div`-1 and wraps; `cke` = (`div` == `clk_div`-1).
- Phase counter `ph` advances on `cke` and wraps after `ovs`-1; `den` = `cke` & (`ph` == `ovs`-1). The interpolator's phase counter therefore wraps to 0 on the same edge at which it loads the new symbol.
- Strobes free-run whenever not in reset, independent of `en` and state.
- FSM states and `den`-edge transitions (`den` = 1 edge):
  - IDLE: `dout` 0. If `en` = 1, go to PRE and reseed the PRBS.
  - PRE: `pre_len` symbols alternating +`amp`, -`amp`, starting with +`amp`. Then go to PAY.
  - PAY: `frame_len` symbols; PRBS bit 0 → +`amp`, bit 1 → -`amp`. Then go to GAP.
  - GAP: `gap_len` symbols of 0. At the end, go to PRE (reseeding the PRBS) if `en` = 1, else IDLE.
- `en` low mid-frame: the current frame completes through GAP; no truncation.
- PRBS9: x^9+x^5+1, 9-bit state `s` seeded 9'h1FF. Per payload symbol, fb = s[8]^s[4]; shift `s` left inserting fb at bit 0; symbol bit = fb. The PRBS advances only in PAY.
- Symbol counter counts `den` events within a state and resets on each transition.
- `dout` is registered and prefetched: it is updated at each `den` edge to the symbol for the next `den`. It holds stable between `den` pulses.
- `sof` = `den` & (`dout` holds PRE symbol index 0).

## Timing
- Reset values: `cke` 0, `den` 0, `dout` 0, `sof` 0, `busy` 0. Also `div` 0, `ph` 0, state IDLE, PRBS 9'h1FF.
- With rst deasserted before cycle 0: first `cke` in cycle `clk_div`-1; first `den` in cycle `clk_div`·`ovs`-1 (cycle 39 at defaults). `den` period is `clk_div`·`ovs` clks.
- `en` is sampled only at `den` edges.
- Latency: `en` rising is sampled at `den` edge N; the first preamble symbol, with `sof`, appears at `den` N+1.
- `busy` rises at the `den` edge where IDLE exits and falls at the edge entering IDLE.
- `rst` mid-frame: all registers return to reset values on the next edge; strobe timing restarts from cycle 0.

## Configuration
- `SYM_SRC_PRBS15_EN` defined: payload uses PRBS15 x^15+x^14+1, 15-bit state seeded 15'h7FFF, fb = s[14]^s[13].
- `SYM_SRC_PRBS15_EN` undefined: PRBS9 as above. Strobe, framing and mapping are unchanged in both cases.

## Test plan
- Reset release, `en` = 0, defaults → `cke` in cycles 3, 7, 11, …; `den` in cycles 39, 79, …; `dout` = 0, `busy` = 0 throughout.
- `en` = 1 from cycle 0 → first preamble symbol with `sof` at `den` #2 (cycle 79). Preamble = +16384, -16384, … for 32 symbols.
- Payload start, PRBS9 → first 9 symbols +16384 ×5, then -16384 ×4. Then 16 zero symbols; the next frame's preamble repeats an identical payload.
- `en` dropped at payload symbol 100 → payload completes 256 symbols plus a 16-symbol gap, then IDLE; `busy` falls and `dout` stays 0.
- `rst` pulsed in mid-payload → all outputs 0 next cycle; with `en` = 1, a new `sof` appears in cycle 79 after release.
- `SYM_SRC_PRBS15_EN` build → first 14 payload symbols are +16384, the 15th is -16384.
